// File: rtl/sr_reg_bank.sv
// rtl/sr_reg_bank.sv - bank of N set/reset flags with conflict policy, edge pulses and conflict tracking
module sr_reg_bank #(
    parameter int           N             = 8,
    parameter logic [N-1:0] INIT          = {N{1'b0}},
    parameter int           CONFLICT_MODE = 0,
    parameter int           CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    input  logic             conflict_clr,
    output logic [N-1:0]     q,
    output logic [N-1:0]     rise,
    output logic [N-1:0]     fall,
    output logic [N-1:0]     conflict,
    output logic             any_conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    // Out-of-range modes collapse to hold so q always has a defined next value.
    localparam int MODE = (CONFLICT_MODE >= 0 && CONFLICT_MODE <= 3) ? CONFLICT_MODE : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     q_next;
    logic [N-1:0]     hit;
    logic             hit_any;
    logic [N-1:0]     conflict_next;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        q_next = q;
        hit    = '0;
        if (en) begin
            hit = s & r;
            for (int i = 0; i < N; i++) begin
                case ({s[i], r[i]})
                    2'b10:   q_next[i] = 1'b1;
                    2'b01:   q_next[i] = 1'b0;
                    2'b11: begin
                        if (MODE == 1)      q_next[i] = 1'b1;
                        else if (MODE == 2) q_next[i] = 1'b0;
                        else if (MODE == 3) q_next[i] = ~q[i];
                        else                q_next[i] = q[i];
                    end
                    default: q_next[i] = q[i];
                endcase
            end
        end
    end

    // A fresh conflict beats a clear landing on the same edge.
    always_comb begin
        hit_any       = |hit;
        conflict_next = (conflict_clr ? '0 : conflict) | hit;
        cnt_next      = conflict_cnt;
        if (conflict_clr) begin
            cnt_next = hit_any ? CNT_W'(1) : '0;
        end else if (hit_any && conflict_cnt != CNT_MAX) begin
            cnt_next = conflict_cnt + CNT_W'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            q            <= INIT;
            rise         <= '0;
            fall         <= '0;
            conflict     <= '0;
            any_conflict <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            q            <= q_next;
            rise         <= q_next & ~q;
            fall         <= ~q_next & q;
            conflict     <= conflict_next;
            any_conflict <= |conflict_next;
            conflict_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_sr_reg_bank.sv
// tb/tb_sr_reg_bank.sv - self-checking bench: one instance per conflict mode against a behavioural model
module tb_sr_reg_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] s;
    logic [7:0] r;
    logic       clr;

    logic [7:0] q_o    [4];
    logic [7:0] rise_o [4];
    logic [7:0] fall_o [4];
    logic [7:0] conf_o [4];
    logic       any_o  [4];
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;
    logic [7:0] cnt_o  [4];

    assign cnt_o[0] = cnt0;
    assign cnt_o[1] = cnt1;
    assign cnt_o[2] = cnt2;
    assign cnt_o[3] = {6'b0, cnt3};

    logic [7:0] m_q    [4];
    logic [7:0] m_rise [4];
    logic [7:0] m_fall [4];
    logic [7:0] m_conf [4];
    logic       m_any  [4];
    int         m_cnt  [4];

    int total = 0;
    int bad   = 0;

    sr_reg_bank #(.N(8), .INIT(8'hA5), .CONFLICT_MODE(0), .CNT_W(8)) u_m0 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .conflict_clr(clr),
        .q(q_o[0]), .rise(rise_o[0]), .fall(fall_o[0]), .conflict(conf_o[0]),
        .any_conflict(any_o[0]), .conflict_cnt(cnt0));
    sr_reg_bank #(.N(8), .INIT(8'hA5), .CONFLICT_MODE(1), .CNT_W(8)) u_m1 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .conflict_clr(clr),
        .q(q_o[1]), .rise(rise_o[1]), .fall(fall_o[1]), .conflict(conf_o[1]),
        .any_conflict(any_o[1]), .conflict_cnt(cnt1));
    sr_reg_bank #(.N(8), .INIT(8'hA5), .CONFLICT_MODE(2), .CNT_W(8)) u_m2 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .conflict_clr(clr),
        .q(q_o[2]), .rise(rise_o[2]), .fall(fall_o[2]), .conflict(conf_o[2]),
        .any_conflict(any_o[2]), .conflict_cnt(cnt2));
    sr_reg_bank #(.N(8), .INIT(8'hA5), .CONFLICT_MODE(3), .CNT_W(2)) u_m3 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .conflict_clr(clr),
        .q(q_o[3]), .rise(rise_o[3]), .fall(fall_o[3]), .conflict(conf_o[3]),
        .any_conflict(any_o[3]), .conflict_cnt(cnt3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance k runs conflict mode k; instance 3 has a 2-bit counter.
    task automatic model_step;
        logic [7:0] nq;
        logic [7:0] hitv;
        int         cmax;
        for (int k = 0; k < 4; k++) begin
            cmax = (k == 3) ? 3 : 255;
            if (!rst) begin
                m_q[k] = 8'hA5; m_rise[k] = 0; m_fall[k] = 0;
                m_conf[k] = 0; m_any[k] = 0; m_cnt[k] = 0;
            end else begin
                nq   = m_q[k];
                hitv = 0;
                if (en) begin
                    for (int i = 0; i < 8; i++) begin
                        if (s[i] && r[i]) begin
                            hitv[i] = 1'b1;
                            if (k == 1)      nq[i] = 1'b1;
                            else if (k == 2) nq[i] = 1'b0;
                            else if (k == 3) nq[i] = !m_q[k][i];
                        end else if (s[i]) begin
                            nq[i] = 1'b1;
                        end else if (r[i]) begin
                            nq[i] = 1'b0;
                        end
                    end
                end
                m_rise[k] = nq & ~m_q[k];
                m_fall[k] = ~nq & m_q[k];
                m_q[k]    = nq;
                m_conf[k] = (clr ? 8'h00 : m_conf[k]) | hitv;
                m_any[k]  = (m_conf[k] != 0);
                if (hitv != 0) m_cnt[k] = clr ? 1 : ((m_cnt[k] < cmax) ? m_cnt[k] + 1 : cmax);
                else if (clr)  m_cnt[k] = 0;
            end
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
        model_step();
    endtask

    task automatic drive(input logic rst_v, input logic en_v, input logic [7:0] s_v,
                         input logic [7:0] r_v, input logic clr_v);
        rst = rst_v; en = en_v; s = s_v; r = r_v; clr = clr_v;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_o[k] !== 8'hA5 || rise_o[k] !== 8'h00 || fall_o[k] !== 8'h00 ||
                conf_o[k] !== 8'h00 || any_o[k] !== 1'b0 || cnt_o[k] !== 8'h00) begin
                bad++;
                $display("FAIL reset_image[%0d] got q=%h rise=%h fall=%h conf=%h any=%b cnt=%0d want q=a5 rest 0",
                         k, q_o[k], rise_o[k], fall_o[k], conf_o[k], any_o[k], cnt_o[k]);
            end
        end
        drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_o[k] !== 8'hA5 || rise_o[k] !== 8'h00 || fall_o[k] !== 8'h00) begin
                bad++;
                $display("FAIL reset_release[%0d] got q=%h rise=%h fall=%h want q=a5 rise=0 fall=0",
                         k, q_o[k], rise_o[k], fall_o[k]);
            end
        end
    endtask

    task automatic test_basic;
        drive(1'b1, 1'b1, 8'h00, 8'hFF, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_o[k] !== 8'h00 || fall_o[k] !== 8'hA5) begin
                bad++;
                $display("FAIL clear_all[%0d] got q=%h fall=%h want q=00 fall=a5", k, q_o[k], fall_o[k]);
            end
        end
        drive(1'b1, 1'b1, 8'h0F, 8'h00, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_o[k] !== 8'h0F || rise_o[k] !== 8'h0F || fall_o[k] !== 8'h00) begin
                bad++;
                $display("FAIL set_pulse[%0d] got q=%h rise=%h fall=%h want q=0f rise=0f fall=00",
                         k, q_o[k], rise_o[k], fall_o[k]);
            end
        end
        drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_o[k] !== 8'h0F || rise_o[k] !== 8'h00) begin
                bad++;
                $display("FAIL rise_one_cycle[%0d] got q=%h rise=%h want q=0f rise=00", k, q_o[k], rise_o[k]);
            end
        end
        drive(1'b1, 1'b1, 8'h00, 8'h03, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_o[k] !== 8'h0C || fall_o[k] !== 8'h03 || rise_o[k] !== 8'h00) begin
                bad++;
                $display("FAIL reset_pulse[%0d] got q=%h fall=%h rise=%h want q=0c fall=03 rise=00",
                         k, q_o[k], fall_o[k], rise_o[k]);
            end
        end
        drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (fall_o[k] !== 8'h00) begin
                bad++;
                $display("FAIL fall_one_cycle[%0d] got fall=%h want 00", k, fall_o[k]);
            end
        end
    endtask

    task automatic test_conflict_modes;
        logic [7:0] exp_q [4];
        logic [7:0] exp_r [4];
        logic [7:0] exp_f [4];
        exp_q = '{8'hF0, 8'hFF, 8'h00, 8'h0F};
        exp_r = '{8'h00, 8'h0F, 8'h00, 8'h0F};
        exp_f = '{8'h00, 8'h00, 8'hF0, 8'hF0};
        drive(1'b1, 1'b1, 8'h00, 8'hFF, 1'b0); tick();
        drive(1'b1, 1'b1, 8'hF0, 8'h00, 1'b0); tick();
        drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0); tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_o[k] !== exp_q[k] || rise_o[k] !== exp_r[k] || fall_o[k] !== exp_f[k]) begin
                bad++;
                $display("FAIL mode%0d_q got q=%h rise=%h fall=%h want q=%h rise=%h fall=%h",
                         k, q_o[k], rise_o[k], fall_o[k], exp_q[k], exp_r[k], exp_f[k]);
            end
            total++;
            if (conf_o[k] !== 8'hFF || cnt_o[k] !== 8'd1 || any_o[k] !== 1'b1) begin
                bad++;
                $display("FAIL mode%0d_conflict got conf=%h cnt=%0d any=%b want conf=ff cnt=1 any=1",
                         k, conf_o[k], cnt_o[k], any_o[k]);
            end
        end
    endtask

    task automatic test_enable;
        logic [7:0] held [4];
        drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b1); tick();
        for (int k = 0; k < 4; k++) held[k] = q_o[k];
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
            tick();
            for (int k = 0; k < 4; k++) begin
                total++;
                if (q_o[k] !== held[k] || rise_o[k] !== 8'h00) begin
                    bad++;
                    $display("FAIL en_hold[%0d] cycle %0d got q=%h rise=%h want q=%h rise=00",
                             k, c, q_o[k], rise_o[k], held[k]);
                end
            end
        end
        drive(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0); tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (conf_o[k] !== 8'h00 || cnt_o[k] !== 8'd0 || q_o[k] !== held[k]) begin
                bad++;
                $display("FAIL en_conflict[%0d] got conf=%h cnt=%0d q=%h want conf=00 cnt=0 q=%h",
                         k, conf_o[k], cnt_o[k], q_o[k], held[k]);
            end
        end
    endtask

    task automatic test_saturation;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
            tick();
        end
        total++;
        if (cnt_o[3] !== 8'd3) begin
            bad++;
            $display("FAIL cnt_saturate got %0d want 3", cnt_o[3]);
        end
        total++;
        if (cnt_o[0] !== 8'd5) begin
            bad++;
            $display("FAIL cnt_count got %0d want 5", cnt_o[0]);
        end
        drive(1'b1, 1'b1, 8'h04, 8'h04, 1'b1); tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (conf_o[k] !== 8'h04 || cnt_o[k] !== 8'd1 || any_o[k] !== 1'b1) begin
                bad++;
                $display("FAIL clr_with_conflict[%0d] got conf=%h cnt=%0d any=%b want conf=04 cnt=1 any=1",
                         k, conf_o[k], cnt_o[k], any_o[k]);
            end
        end
        drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b1); tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (conf_o[k] !== 8'h00 || cnt_o[k] !== 8'd0 || any_o[k] !== 1'b0) begin
                bad++;
                $display("FAIL clr_plain[%0d] got conf=%h cnt=%0d any=%b want all 0",
                         k, conf_o[k], cnt_o[k], any_o[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0); tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_o[k] !== 8'hA5 || rise_o[k] !== 8'h00 || fall_o[k] !== 8'h00 ||
                conf_o[k] !== 8'h00 || any_o[k] !== 1'b0 || cnt_o[k] !== 8'd0) begin
                bad++;
                $display("FAIL mid_reset[%0d] got q=%h rise=%h fall=%h conf=%h any=%b cnt=%0d want q=a5 rest 0",
                         k, q_o[k], rise_o[k], fall_o[k], conf_o[k], any_o[k], cnt_o[k]);
            end
        end
        drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0); tick();
        total++;
        if (q_o[3] !== 8'h5A || rise_o[3] !== 8'h5A || fall_o[3] !== 8'hA5 || cnt_o[3] !== 8'd1) begin
            bad++;
            $display("FAIL toggle_resume got q=%h rise=%h fall=%h cnt=%0d want q=5a rise=5a fall=a5 cnt=1",
                     q_o[3], rise_o[3], fall_o[3], cnt_o[3]);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
            tick();
            for (int k = 0; k < 4; k++) begin
                total++;
                if (q_o[k] !== m_q[k] || rise_o[k] !== m_rise[k] || fall_o[k] !== m_fall[k] ||
                    conf_o[k] !== m_conf[k] || any_o[k] !== m_any[k] || cnt_o[k] !== 8'(m_cnt[k])) begin
                    bad++;
                    $display("FAIL random[%0d] cycle %0d got q=%h rise=%h fall=%h conf=%h any=%b cnt=%0d want q=%h rise=%h fall=%h conf=%h any=%b cnt=%0d",
                             k, c, q_o[k], rise_o[k], fall_o[k], conf_o[k], any_o[k], cnt_o[k],
                             m_q[k], m_rise[k], m_fall[k], m_conf[k], m_any[k], m_cnt[k]);
                end
            end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        test_reset();
        test_basic();
        test_conflict_modes();
        test_enable();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
